// File: rtl/seq_matrix_multiplier.sv
// seq_matrix_multiplier: sequential Result = A x B using one multiply-accumulate per clock
//
// Parameters: A_param (rows of A/Result), B_param (inner dimension), C_param (columns of B/Result),
//             DATA_W (unsigned operand element width), RES_W (Result element width)
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - begin a computation; only honoured in IDLE
//   A1d    - flat A, element (r,c) at [(r*B_param+c)*DATA_W +: DATA_W]
//   B1d    - flat B, element (r,c) at [(r*C_param+c)*DATA_W +: DATA_W]
//   busy   - high from the start edge until the final MAC edge
//   done   - one-cycle pulse when Result holds the new product
//   Result - flat result, element (r,c) at [(r*C_param+c)*RES_W +: RES_W]
// Build option: define SEQ_MATMUL_SATURATE_EN to saturate each element to 2^RES_W-1
//               instead of wrapping to the low RES_W bits.
module seq_matrix_multiplier #(
   parameter int A_param = 3,
   parameter int B_param = 3,
   parameter int C_param = 8,
   parameter int DATA_W  = 8,
   parameter int RES_W   = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [A_param*B_param*DATA_W-1:0] A1d,
   input  logic [B_param*C_param*DATA_W-1:0] B1d,
   output logic                             busy,
   output logic                             done,
   output logic [A_param*C_param*RES_W-1:0]  Result
);
   // Wide enough to sum B_param full-scale products without overflow
   localparam int ACC_W = 2*DATA_W + $clog2(B_param) + 1;
   localparam int FW    = ACC_W > RES_W ? ACC_W : RES_W;
   localparam int IW    = A_param > 1 ? $clog2(A_param) : 1;
   localparam int JW    = C_param > 1 ? $clog2(C_param) : 1;
   localparam int KW    = B_param > 1 ? $clog2(B_param) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(A_param-1);
   localparam logic [JW-1:0] J_LAST = JW'(C_param-1);
   localparam logic [KW-1:0] K_LAST = KW'(B_param-1);
   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
   state_t                            state;
   logic [A_param*B_param*DATA_W-1:0] a_q;
   logic [B_param*C_param*DATA_W-1:0] b_q;
   logic [A_param*C_param*RES_W-1:0]  buf_q, buf_nxt;
   logic [ACC_W-1:0]                  acc, sum;
   logic [2*DATA_W-1:0]               prod;
   logic [DATA_W-1:0]                 a_el, b_el;
   logic [RES_W-1:0]                  fit_v;
   logic [IW-1:0]                     i;
   logic [JW-1:0]                     j;
   logic [KW-1:0]                     k;
   logic                              i_last, j_last, k_last;
   assign i_last = i == I_LAST;
   assign j_last = j == J_LAST;
   assign k_last = k == K_LAST;
   always_comb begin
      a_el = a_q[(int'(i)*B_param + int'(k))*DATA_W +: DATA_W];
      b_el = b_q[(int'(k)*C_param + int'(j))*DATA_W +: DATA_W];
      prod = {{DATA_W{1'b0}}, a_el} * {{DATA_W{1'b0}}, b_el};
      sum  = acc + ACC_W'(prod);
`ifdef SEQ_MATMUL_SATURATE_EN
      fit_v = FW'(sum) > FW'({RES_W{1'b1}}) ? {RES_W{1'b1}} : RES_W'(sum);
`else
      fit_v = RES_W'(sum);
`endif
      // Buffer as it will be after this element is written, so the final
      // element reaches Result on the same edge it is produced
      buf_nxt = buf_q;
      buf_nxt[(int'(i)*C_param + int'(j))*RES_W +: RES_W] = fit_v;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         Result <= '0;
         a_q    <= '0;
         b_q    <= '0;
         buf_q  <= '0;
         acc    <= '0;
         i      <= '0;
         j      <= '0;
         k      <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q   <= A1d;
                  b_q   <= B1d;
                  acc   <= '0;
                  i     <= '0;
                  j     <= '0;
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= MAC;
               end
            end
            MAC: begin
               if (!k_last) begin
                  acc <= sum;
                  k   <= k + KW'(1);
               end else begin
                  buf_q <= buf_nxt;
                  acc   <= '0;
                  k     <= '0;
                  j     <= j_last ? '0 : j + JW'(1);
                  i     <= j_last ? (i_last ? '0 : i + IW'(1)) : i;
                  if (i_last && j_last) begin
                     Result <= buf_nxt;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_seq_matrix_multiplier.sv
// tb_seq_matrix_multiplier: randomized and directed checks of seq_matrix_multiplier against an arithmetic model
module tb_seq_matrix_multiplier;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         start, s_start;
   logic [71:0]  a1d;
   logic [191:0] b1d;
   logic [191:0] result;
   logic         busy, done;
   logic [15:0]  s_a, s_b;
   logic [39:0]  s_res;
   logic         s_busy, s_done;
   int           errors = 0;
   int           checks = 0;
   logic [191:0] last_exp = '0;

   always #5 clk = ~clk;

   seq_matrix_multiplier dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A1d(a1d), .B1d(b1d),
      .busy(busy), .done(done), .Result(result)
   );

   seq_matrix_multiplier #(.A_param(2), .B_param(2), .C_param(2), .DATA_W(4), .RES_W(10)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(s_start), .A1d(s_a), .B1d(s_b),
      .busy(s_busy), .done(s_done), .Result(s_res)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Plain matrix product from the element layout, with wrap or saturation per element
   function automatic logic [255:0] model(input logic [255:0] a, input logic [255:0] b,
                                          input int ar, input int bc, input int cc,
                                          input int dw, input int rw);
      logic [255:0] res = '0;
      logic [255:0] m   = (256'd1 << dw) - 256'd1;
      longint       s, x, y, mx;
      mx = (longint'(1) << rw) - 1;
      for (int r = 0; r < ar; r++)
         for (int c = 0; c < cc; c++) begin
            s = 0;
            for (int n = 0; n < bc; n++) begin
               x = longint'((a >> ((r*bc + n)*dw)) & m);
               y = longint'((b >> ((n*cc + c)*dw)) & m);
               s += x * y;
            end
`ifdef SEQ_MATMUL_SATURATE_EN
            s = s > mx ? mx : s;
`else
            s = s & mx;
`endif
            res |= 256'(s) << ((r*cc + c)*rw);
         end
      return res;
   endfunction

   task automatic run(input logic [71:0] a, input logic [191:0] b, input bit disturb, input string tag);
      logic [255:0] full;
      logic [191:0] exp;
      int           n;
      bit           stable, quiet;
      full = model(256'(a), 256'(b), 3, 3, 8, 8, 8);
      exp  = full[191:0];
      @(negedge clk);
      a1d   = a;
      b1d   = b;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_t0"}, 256'(busy), 256'(1));
      n      = 0;
      stable = 1'b1;
      while (busy && n < 200) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (busy) stable &= (result === last_exp) && !done;
         if (disturb && n == 5) begin
            a1d   = '0;
            b1d   = '0;
            start = 1'b1;
         end
      end
      start = 1'b0;
      check({tag, "_cycles"}, 256'(n), 256'(72));
      check({tag, "_done"}, 256'(done), 256'(1));
      check({tag, "_result"}, 256'(result), 256'(exp));
      check({tag, "_stable"}, 256'(stable), 256'(1));
      quiet = 1'b1;
      repeat (4) begin
         @(negedge clk);
         quiet &= !busy && !done && (result === exp);
      end
      check({tag, "_quiet_after"}, 256'(quiet), 256'(1));
      last_exp = exp;
   endtask

   initial begin
      logic [71:0]  a;
      logic [191:0] b;
      logic [255:0] sfull;
      logic [39:0]  sexp;
      int           cyc, pulses, first, lastp;
      bit           ok, gap_ok;
      rst_n   = 1'b0;
      start   = 1'b0;
      s_start = 1'b0;
      a1d     = '0;
      b1d     = '0;
      s_a     = '0;
      s_b     = '0;
      #3;
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_done", 256'(done), 256'(0));
      check("rst_result", 256'(result), 256'(0));
      check("rst_small_result", 256'(s_res), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;

      a = '0;
      b = '0;
      for (int r = 0; r < 3; r++) a[(r*3 + r)*8 +: 8] = 8'd1;
      for (int e = 0; e < 24; e++) b[e*8 +: 8] = 8'(e);
      run(a, b, 1'b0, "identity");
      check("identity_eq_b", 256'(result), 256'(b));

      run({72{1'b1}}, {192{1'b1}}, 1'b0, "all_ff");
`ifdef SEQ_MATMUL_SATURATE_EN
      check("all_ff_const", 256'(result), 256'({24{8'hFF}}));
`else
      check("all_ff_const", 256'(result), 256'({24{8'h03}}));
`endif

      for (int t = 0; t < 3; t++) begin
         a = {$urandom, $urandom, $urandom};
         b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         run(a, b, 1'b0, "random");
      end

      a = {$urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run(a, b, 1'b1, "disturb");

      @(negedge clk);
      a1d   = {$urandom, $urandom, $urandom};
      b1d   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 256'(busy), 256'(0));
      check("midrst_done", 256'(done), 256'(0));
      check("midrst_result", 256'(result), 256'(0));
      @(negedge clk);
      rst_n    = 1'b1;
      last_exp = '0;
      a = {$urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run(a, b, 1'b0, "after_rst");

      s_a   = 16'h4321;
      s_b   = 16'h8765;
      sfull = model(256'(s_a), 256'(s_b), 2, 2, 2, 4, 10);
      sexp  = sfull[39:0];
      @(negedge clk);
      s_start = 1'b1;
      cyc     = 0;
      pulses  = 0;
      first   = 0;
      lastp   = 0;
      ok      = 1'b1;
      gap_ok  = 1'b1;
      repeat (45) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (s_done) begin
            pulses++;
            if (pulses == 1) first = cyc;
            else if (cyc - lastp != 10) gap_ok = 1'b0;
            lastp = cyc;
         end
         if (pulses > 0) ok &= s_res === sexp;
      end
      s_start = 1'b0;
      check("b2b_first_done", 256'(first), 256'(9));
      check("b2b_pulses", 256'(pulses), 256'(4));
      check("b2b_period", 256'(gap_ok), 256'(1));
      check("b2b_stable", 256'(ok), 256'(1));
      check("b2b_result", 256'(s_res), 256'({10'd50, 10'd43, 10'd22, 10'd19}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/seq_matrix_multiplier.md
Name: seq_matrix_multiplier

Overview:
- Sequential, parametrised successor to the team's combinational matrix multiplier.
- Computes Result = A x B, with A of size A_param x B_param and B of size B_param x C_param.
- Uses a single multiply-accumulate unit, one product per clock, with a start/busy/done handshake.
- Generalised element widths. Operand, result and index packing match the existing flat-vector format, so it is a drop-in for datapaths needing fewer multipliers.

Parameters:
A_param, 3, rows of A and of Result
B_param, 3, columns of A = rows of B (inner dimension)
C_param, 8, columns of B and of Result
DATA_W, 8, width of each operand element (unsigned)
RES_W, 8, width of each Result element (unsigned)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
A1d  input  A_param*B_param*DATA_W  flat A; element (r,c) at bits [(r*B_param+c)*DATA_W +: DATA_W]
B1d  input  B_param*C_param*DATA_W  flat B; element (r,c) at bits [(r*C_param+c)*DATA_W +: DATA_W]
busy  output  1  high while computing
done  output  1  one-cycle pulse when Result is valid
Result  output  A_param*C_param*RES_W  flat result; element (r,c) at bits [(r*C_param+c)*RES_W +: RES_W]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, Result=0.
  - Internal operand copies, accumulator and indices i, j, k all cleared.
- States: IDLE, MAC, DONE.
- IDLE:
  - On an edge with start=1: latch A1d and B1d into internal registers, set i=j=k=0, acc=0, go to MAC, busy=1.
  - start=0: stay in IDLE.
- MAC, each edge:
  - Compute sum = acc + A[i][k]*B[k][j].
  - Product width is 2*DATA_W. Accumulator width is 2*DATA_W + clog2(B_param)+1, so no internal overflow.
  - If k<B_param-1: acc=sum, k++.
  - If k==B_param-1: write fit(sum) into result buffer element (i,j); acc=0; k=0; j++ (j wraps to 0 with i++ when j==C_param-1).
  - On the write for (A_param-1, C_param-1): copy the full buffer, including this element, into Result; go to DONE; busy=0.
- DONE:
  - done=1 for exactly one cycle, then IDLE on the next edge.
  - start is ignored in DONE.
- Latency:
  - Start sampled at edge t0; MAC edges t1..tN, where N = A_param*B_param*C_param.
  - done is high in the cycle after edge tN; busy is high from t0 to tN.
  - Defaults: N=72.
- Result stability:
  - Result changes only on the edge entering DONE.
  - It holds the previous product throughout a computation, and holds the new value until the next completion or reset.
- Operands: A1d and B1d may change freely after the start edge; only the latched copies are used.
- start while busy or in DONE: ignored, with no effect on the computation.
- Back-to-back operation: start held high continuously gives a new computation every N+2 cycles.
- fit(): see Optional Feature. Default fit = truncation to the low RES_W bits (modulo 2^RES_W), matching the existing block's wrap behaviour.
- Reset mid-operation: immediate abort, all outputs and state as at reset; no partial Result.
- Degenerate sizes: every parameter must be >=1. B_param=1 gives one MAC cycle per element.

Optional Feature:
- Macro: SEQ_MATMUL_SATURATE_EN.
- Defined: fit(sum) = (sum > 2^RES_W-1) ? 2^RES_W-1 : sum[RES_W-1:0]. Saturation is per element and evaluated at element write time.
- Undefined: fit(sum) = sum[RES_W-1:0], plain wrap; no comparator is synthesised.

Test Plan:
1. A = 3x3 identity, B elements = r*8+c (0..23), pulse start:
   - busy for 72 cycles; done pulse in the cycle after the 72nd MAC edge.
   - Result == B.
2. All A and B elements = 0xFF, defaults:
   - macro undefined: every Result element = 0x03 (195075 mod 256).
   - macro defined: every Result element = 0xFF.
3. Operand changes and ignored start:
   - Change A1d and B1d to all zero, and raise start, 5 cycles after the start edge.
   - Result still reflects the original operands.
   - No second computation: busy falls at cycle 72, done pulses once.
4. Reset mid-operation: assert rst_n=0 asynchronously at MAC cycle 30:
   - busy, done and Result go to 0 immediately, state returns to IDLE.
   - A fresh start then completes correctly in 72 cycles.
5. Back-to-back with start held high:
   - Parameters A=2, B=2, C=2, DATA_W=4, RES_W=10; A = [[1,2],[3,4]], B = [[5,6],[7,8]].
   - Result = [[19,22],[43,50]].
   - done pulses every 10 cycles, and Result is stable between pulses.
